pwm_mc: RTL and testbench
=========================

PWM_MC -- requirements
Module: pwm_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and duty width in bits (2..16).
REQ-002 SHALL have parameter CH, default 4, number of PWM channels (1..16).
REQ-003 SHALL have parameter PRESC_W, default 4, prescaler register width.
REQ-004 SHALL have port CLK  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port aRSTin  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port duty_in  input  CH*WIDTH  packed duty values; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port duty_wr  input  CH  per-channel write strobe, one cycle, loads the channel shadow register.
REQ-008 SHALL have port center  input  1  mode request: 0 edge-aligned, 1 center-aligned.
REQ-009 SHALL have port presc  input  PRESC_W  count-tick divider; tick every presc+1 cycles.
REQ-010 SHALL have port pending  output  CH  shadow written but not yet transferred.
REQ-011 SHALL have port period_start  output  1  one-cycle pulse at each period boundary.
REQ-012 SHALL have port PWM  output  CH  registered PWM outputs.

Function
REQ-013 SHALL synchronise reset internally: arst asserts immediately with aRSTin and deasserts on the 2nd CLK rising edge after aRSTin falls; all other state is cleared by arst.
REQ-014 SHALL advance the prescaler every cycle, with tick=1 when prescaler==presc, after which it returns to 0; presc=0 gives a tick every cycle. A presc change takes effect at the next prescaler compare.
REQ-015 SHALL advance the shared counter cnt only on tick.
REQ-016 In edge mode, cnt SHALL count 0..2^WIDTH-1 and wrap to 0 (period 2^WIDTH ticks).
REQ-017 In center mode, cnt SHALL count up 0..2^WIDTH-1, then down to 0, without repeating endpoints (period 2*(2^WIDTH-1) ticks).
REQ-018 SHALL define the period boundary as the tick on which cnt becomes 0 from a nonzero value; period_start SHALL pulse in the cycle after that tick.
REQ-019 SHALL latch center into the active mode only at a period boundary. When switching to center mode, counting SHALL start upward.
REQ-020 On duty_wr[k], SHALL store the channel-k slice of duty_in into shadow[k] and set pending[k].
REQ-021 At a period boundary, SHALL copy shadow[k] to active[k] for every k with pending[k]=1, and clear pending[k].
REQ-022 If duty_wr[k] coincides with a boundary, the transfer SHALL use the shadow value from before that cycle, the new value SHALL land in shadow, and pending[k] SHALL remain 1.
REQ-023 Each output PWM[k] SHALL be the registered value of (cnt < active[k]), giving one cycle of latency from cnt.
REQ-024 active=0 SHALL give constant low. In edge mode, active=2^WIDTH-1 SHALL give low for exactly one tick per period.
REQ-025 Duty arithmetic SHALL be unsigned at WIDTH bits, with no saturation logic required.

Reset
REQ-026 While arst is asserted: prescaler=0, cnt=0, active mode=edge, shadow[k]=active[k]=2^(WIDTH-1), pending=0, period_start=0, PWM=all ones.
REQ-027 A reset asserted mid-period SHALL abort the period immediately, discarding pending writes.

Configuration
REQ-028 When macro PWM_MC_POLARITY_EN is defined, SHALL add port pol  input  CH. When pol[k]=1, PWM[k] SHALL be inverted after the output register, and reset SHALL still drive the register to all ones.
REQ-029 When PWM_MC_POLARITY_EN is not defined, the pol port SHALL be absent and outputs SHALL be active-high.

Structure
REQ-030 Package pwm_mc_pkg SHALL hold the mode enum (MODE_EDGE, MODE_CENTER), the direction enum (DIR_UP, DIR_DOWN), and the parameter limit constants.
REQ-031 Per-channel shadow, active, pending and compare register logic SHALL live in sub-module pwm_mc_chan, instantiated CH times by generate. The reset synchroniser, prescaler and counter SHALL stay in pwm_mc.

Verification
REQ-032 Reset test: pulse aRSTin mid-period with WIDTH=8. Required: PWM=all ones during reset; 2 cycles after release cnt runs; duty=128 gives 128 high ticks per 256-tick period.
REQ-033 Double-buffer test: write duty 64 to ch0 mid-period. Required: pending[0]=1; the old duty holds until the boundary; the next period has 64 high ticks; pending[0] clears.
REQ-034 Collision test: write 32 on the boundary cycle, after a prior write of 200. Required: the period uses 200, then 32 in the following period; pending stays 1 across the boundary.
REQ-035 Center mode test: center=1, presc=0, duty=100. Required: period 510 cycles; high pulse 199 cycles, centered on cnt=0; the mode switch occurs only at a boundary.
REQ-036 Prescaler and limits test: presc=3, duty 0 and 255. Required: the count tick is every 4 cycles; ch with duty 0 is always low; ch with duty 255 is low for 4 cycles per period.

Source files
------------

// File: rtl/pwm_mc_pkg.sv
// pwm_mc_pkg: shared types and parameter limits for the multi-channel PWM block.
package pwm_mc_pkg;

    // Legal parameter ranges for pwm_mc.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    localparam int CH_MIN    = 1;
    localparam int CH_MAX    = 16;

    // Active counting mode, latched only at a period boundary.
    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    // Counter direction, meaningful only in center mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_mc_chan.sv
// pwm_mc_chan: one PWM channel. Holds a double-buffered duty value
// (shadow written any time, active updated only at a period boundary)
// and the registered compare output.
module pwm_mc_chan
    import pwm_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             wr_i,
    input  logic             boundary_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pending_o,
    output logic             pwm_o
);

    // Reset duty is half scale.
    localparam logic [WIDTH-1:0] DUTY_RST = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;

    // Next-state: boundary transfer uses the old shadow; a coincident write
    // lands in shadow and keeps pending set for the following boundary.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary_i && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            active_d  = active_q;
        end
        if (wr_i) begin
            shadow_d  = duty_i;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
        end
        pwm_d = (cnt_i < active_q);
    end

    // Channel state registers; reset drives the output high.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shadow_q  <= DUTY_RST;
            active_q  <= DUTY_RST;
            pending_q <= 1'b0;
            pwm_q     <= 1'b1;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pending_o = pending_q;
    assign pwm_o     = pwm_q;

endmodule

// File: rtl/pwm_mc.sv
// pwm_mc: multi-channel PWM with shared prescaler and counter, edge- or
// center-aligned counting, and per-channel double-buffered duty.
// Optional feature: define PWM_MC_POLARITY_EN to add per-channel output
// inversion via port pol.
module pwm_mc
    import pwm_mc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CH      = 4,
    parameter int PRESC_W = 4
) (
    input  logic                  CLK,
    input  logic                  aRSTin,
    input  logic [CH*WIDTH-1:0]   duty_in,
    input  logic [CH-1:0]         duty_wr,
    input  logic                  center,
    input  logic [PRESC_W-1:0]    presc,
`ifdef PWM_MC_POLARITY_EN
    input  logic [CH-1:0]         pol,
`endif
    output logic [CH-1:0]         pending,
    output logic                  period_start,
    output logic [CH-1:0]         PWM
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [1:0]         rst_sync_q;
    logic               arst;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_s;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic               boundary_s;
    logic               period_start_q;
    logic [CH-1:0]      pwm_s;

    // Reset synchroniser: assert at once, release on the 2nd edge after aRSTin falls.
    always_ff @(posedge CLK or posedge aRSTin) begin
        if (aRSTin) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign arst = rst_sync_q[1];

    // Prescaler compare and counter/mode next-state logic.
    always_comb begin
        tick_s     = (presc_q == presc);
        presc_d    = tick_s ? {PRESC_W{1'b0}} : presc_q + PRESC_W'(1);
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        boundary_s = 1'b0;
        if (tick_s) begin
            case (mode_q)
                MODE_EDGE: begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                MODE_CENTER: begin
                    if (dir_q == DIR_DOWN && cnt_q != {WIDTH{1'b0}}) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d = cnt_q - WIDTH'(1);
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                        dir_d = DIR_UP;
                    end
                end
                default: begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            endcase
            // Boundary: counter returns to zero from a nonzero value.
            if (cnt_d == {WIDTH{1'b0}} && cnt_q != {WIDTH{1'b0}}) begin
                boundary_s = 1'b1;
                mode_d     = center ? MODE_CENTER : MODE_EDGE;
                dir_d      = DIR_UP;
            end else begin
                boundary_s = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler, counter, mode and period-start registers.
    always_ff @(posedge CLK or posedge arst) begin
        if (arst) begin
            presc_q        <= {PRESC_W{1'b0}};
            cnt_q          <= {WIDTH{1'b0}};
            mode_q         <= MODE_EDGE;
            dir_q          <= DIR_UP;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            dir_q          <= dir_d;
            period_start_q <= boundary_s;
        end
    end

    assign period_start = period_start_q;

    for (genvar k = 0; k < CH; k++) begin : g_chan
        pwm_mc_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i      (CLK),
            .arst_i     (arst),
            .duty_i     (duty_in[k*WIDTH +: WIDTH]),
            .wr_i       (duty_wr[k]),
            .boundary_i (boundary_s),
            .cnt_i      (cnt_q),
            .pending_o  (pending[k]),
            .pwm_o      (pwm_s[k])
        );
    end

`ifdef PWM_MC_POLARITY_EN
    assign PWM = pwm_s ^ pol;
`else
    assign PWM = pwm_s;
`endif

endmodule

// File: tb/tb_pwm_mc.sv
// tb_pwm_mc: directed self-checking bench for pwm_mc (WIDTH=8, CH=4, PRESC_W=4).
module tb_pwm_mc;

    localparam int WIDTH   = 8;
    localparam int CH      = 4;
    localparam int PRESC_W = 4;

    logic                CLK     = 1'b0;
    logic                aRSTin  = 1'b1;
    logic [CH*WIDTH-1:0] duty_in = '0;
    logic [CH-1:0]       duty_wr = '0;
    logic                center  = 1'b0;
    logic [PRESC_W-1:0]  presc   = '0;
`ifdef PWM_MC_POLARITY_EN
    logic [CH-1:0]       pol     = '0;
`endif
    logic [CH-1:0]       pending;
    logic                period_start;
    logic [CH-1:0]       PWM;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt [CH];
    int cyc;
    int ps_seen;

    pwm_mc #(
        .WIDTH   (WIDTH),
        .CH      (CH),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK          (CLK),
        .aRSTin       (aRSTin),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .center       (center),
        .presc        (presc),
`ifdef PWM_MC_POLARITY_EN
        .pol          (pol),
`endif
        .pending      (pending),
        .period_start (period_start),
        .PWM          (PWM)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample on falling edges until period_start is seen or max_n elapses.
    task automatic run(input int max_n);
        cyc     = 0;
        ps_seen = 0;
        for (int k = 0; k < CH; k++) hi_cnt[k] = 0;
        for (int i = 1; i <= max_n; i++) begin
            @(negedge CLK);
            cyc = i;
            for (int k = 0; k < CH; k++) if (PWM[k]) hi_cnt[k]++;
            if (period_start) begin
                ps_seen = 1;
                break;
            end
        end
    endtask

    task automatic write_duty(input logic [CH-1:0] mask, input logic [CH*WIDTH-1:0] data);
        duty_in = data;
        duty_wr = mask;
        @(negedge CLK);
        duty_wr = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check_val("rst_pwm", int'(PWM), 15);
        check_val("rst_pending", int'(pending), 0);
        check_val("rst_period_start", int'(period_start), 0);

        // Release: 2 sync cycles + 256 ticks to first boundary
        aRSTin = 1'b0;
        run(400);
        check_val("rel_ps_seen", ps_seen, 1);
        check_val("rel_to_ps", cyc, 258);
        check_val("rel_hi0", hi_cnt[0], 130);
        run(400);
        check_val("edge_period", cyc, 256);
        for (int k = 0; k < CH; k++) check_val($sformatf("edge_hi%0d", k), hi_cnt[k], 128);

        // Reset mid-period discards a pending write
        repeat (50) @(negedge CLK);
        write_duty(4'b0001, {24'd0, 8'd10});
        check_val("midrst_pend_before", int'(pending), 1);
        aRSTin = 1'b1;
        @(negedge CLK);
        check_val("midrst_pwm", int'(PWM), 15);
        check_val("midrst_pending", int'(pending), 0);
        repeat (2) @(negedge CLK);
        aRSTin = 1'b0;
        run(400);
        check_val("midrst_to_ps", cyc, 258);
        run(400);
        check_val("midrst_period", cyc, 256);
        check_val("midrst_hi0", hi_cnt[0], 128);

        // Double buffer: write 64 mid-period
        repeat (100) @(negedge CLK);
        write_duty(4'b0001, {24'd0, 8'd64});
        check_val("dbuf_pending", int'(pending), 1);
        run(400);
        check_val("dbuf_rest_cyc", cyc, 155);
        check_val("dbuf_old_hi0", hi_cnt[0], 27);
        check_val("dbuf_pending_clr", int'(pending), 0);
        run(400);
        check_val("dbuf_period", cyc, 256);
        check_val("dbuf_new_hi0", hi_cnt[0], 64);
        check_val("dbuf_hi1", hi_cnt[1], 128);

        // Collision: 200 mid-period, then 32 on the boundary cycle
        repeat (50) @(negedge CLK);
        write_duty(4'b0001, {24'd0, 8'd200});
        check_val("coll_pending1", int'(pending), 1);
        repeat (204) @(negedge CLK);
        write_duty(4'b0001, {24'd0, 8'd32});
        check_val("coll_on_boundary", int'(period_start), 1);
        check_val("coll_pending_kept", int'(pending), 1);
        run(400);
        check_val("coll_period", cyc, 256);
        check_val("coll_hi0_200", hi_cnt[0], 200);
        check_val("coll_pending_clr", int'(pending), 0);
        run(400);
        check_val("coll_hi0_32", hi_cnt[0], 32);

        // Prescaler 3 with duty 0 and 255
        presc = 4'd3;
        write_duty(4'b0110, {8'd0, 8'd255, 8'd0, 8'd0});
        run(2000);
        check_val("presc_to_ps", cyc, 1023);
        run(2000);
        check_val("presc_period", cyc, 1024);
        check_val("presc_hi0", hi_cnt[0], 128);
        check_val("presc_duty0", hi_cnt[1], 0);
        check_val("presc_duty255", hi_cnt[2], 1020);
        check_val("presc_hi3", hi_cnt[3], 512);

        // Center mode requested mid-period takes effect at the boundary
        presc = 4'd0;
        write_duty(4'b0001, {24'd0, 8'd100});
        repeat (9) @(negedge CLK);
        center = 1'b1;
        run(600);
        check_val("ctr_switch_wait", cyc, 246);
        run(600);
        check_val("ctr_ps_seen", ps_seen, 1);
        check_val("ctr_period", cyc, 510);
        check_val("ctr_hi0", hi_cnt[0], 199);
        check_val("ctr_hi1", hi_cnt[1], 0);
        check_val("ctr_hi2", hi_cnt[2], 509);
        check_val("ctr_hi3", hi_cnt[3], 255);
        check_val("ctr_pwm0_at_zero", int'(PWM[0]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
